fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch reader for the sequential Y86-32 core. Takes the PC latched by
//  the PC register, reads a variable-length instruction (1/2/5/6 bytes) byte-serially
//  from instruction memory, and presents decoded fields plus valP to the datapath.
//  Its done pulse tells the core that valP/valC are ready for next-PC selection.
// PARAMETERS
//  ADDR_W      32  PC / memory address width
//  VALC_BYTES  4   constant-word bytes, little-endian; valC width = 8*VALC_BYTES
// PORTS
//  CLK         in   1        single clock; all state updates on posedge
//  RESET       in   1        asynchronous, active-high reset
//  fetch_start in   1        one-cycle request; pc sampled with it
//  pc          in   ADDR_W   address of instruction to fetch
//  busy        out  1        high from the cycle after an accepted start until done
//  fetch_done  out  1        one-cycle pulse; all field outputs valid from this cycle
//  mem_rd      out  1        byte read request, held until mem_ready
//  mem_addr    out  ADDR_W   byte address, stable while mem_rd high
//  mem_rdata   in   8        read data, valid when mem_ready
//  mem_ready   in   1        completes current read (zero-wait allowed)
//  mem_error   in   1        qualifies mem_ready: access fault
//  icode       out  4        opcode high nibble
//  ifun        out  4        opcode low nibble
//  rA, rB      out  4 each   register specifiers; 4'hF when absent
//  valC        out  8*VALC_BYTES  constant/destination; 0 when absent
//  valP        out  ADDR_W   pc + instruction length, modulo 2^ADDR_W
//  instr_valid out  1        0 for illegal icode
//  imem_error  out  1        1 if any byte fetch faulted
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-fetch): state IDLE, busy=0, fetch_done=0,
//    mem_rd=0, mem_addr=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0,
//    instr_valid=0, imem_error=0. Fetch in progress is abandoned, no done pulse.
//  - States: IDLE -> OPC -> (REGS) -> (CONST xVALC_BYTES) -> DONE -> IDLE.
//  - IDLE: fetch_start=1 latches pc into base, clears outputs to reset values, goes OPC.
//    fetch_start while busy or in DONE is ignored.
//  - Each byte state drives mem_rd=1, mem_addr=base+offset (offset 0..5, wraps mod 2^ADDR_W);
//    advances only on a cycle with mem_ready=1. Byte consumed on that edge.
//  - Length by icode: 0 halt,1 nop,9 ret ->1; 2 rrmovl/cmov,6 opl,A push,B pop ->2;
//    7 jXX,8 call ->5 (opcode+valC, no REGS); 3 irmovl,4 rmmovl,5 mrmovl ->6.
//    icode>4'hB: instr_valid=0, length 1, straight to DONE.
//  - REGS byte: rA=data[7:4], rB=data[3:0]. CONST bytes: valC[8k+7:8k]=byte k.
//  - mem_ready&mem_error on any byte: imem_error=1, instr_valid=0, go DONE at once;
//    fields already captured retained, valP=base+bytes accepted incl. faulting one.
//  - DONE: fetch_done=1 for exactly one cycle, valP=base+length; outputs then hold
//    until next accepted start. busy=1 in OPC..CONST, 0 in IDLE and DONE.
//  - Latency with zero-wait memory: start at cycle 0, byte k accepted at cycle 1+k,
//    done at cycle 1+length. Each wait cycle adds one.
//  - mem_rd never high in IDLE/DONE; no read issued beyond instruction length.
// STRUCTURE
//  - Shared package y86_pkg: icode localparams (I_HALT..I_POPL), REG_NONE=4'hF,
//    function instr_len(icode) and has_regs/has_valc predicates (also used by decode).
//  - Sub-module fetch_len_decode: combinational icode -> {valid, has_regs, has_valc,
//    len}; FSM, byte counter and field registers stay in fetch_unit.
// TESTING
//  1 nop @pc=0x10, zero-wait: byte 0x10 -> done cycle 2, icode=1, rA=rB=F, valP=0x11.
//  2 irmovl 30 F3 78 56 34 12 @0x100: -> rB=3, valC=0x12345678, valP=0x106, done cycle 7.
//  3 call 80 00 02 00 00 @0x20 with 2 wait cycles per byte: -> done cycle 16,
//    valC=0x200, rA=rB=F, mem_addr held stable during waits.
//  4 pc=0xFFFFFFFE rrmovl 20 12: -> addrs 0xFFFFFFFE,0xFFFFFFFF; valP=0x00000000.
//  5 opcode 0xC0: -> instr_valid=0, one read, done cycle 2; mem_error on 3rd byte of
//    mrmovl @0x40 -> imem_error=1, valP=0x43, no further reads.
//  6 RESET asserted during CONST of irmovl, start issued 2 cycles after release:
//    -> all outputs reset immediately, no done for aborted fetch, new fetch correct.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-32 opcode constants and instruction-shape helpers used by fetch and decode.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVL = 4'h2;
   localparam logic [3:0] I_IRMOVL = 4'h3;
   localparam logic [3:0] I_RMMOVL = 4'h4;
   localparam logic [3:0] I_MRMOVL = 4'h5;
   localparam logic [3:0] I_OPL    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHL  = 4'hA;
   localparam logic [3:0] I_POPL   = 4'hB;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPC,
      S_REGS,
      S_CONST,
      S_DONE
   } fetch_state_e;

   function automatic logic valid_icode(input logic [3:0] ic);
      return ic <= I_POPL;
   endfunction

   function automatic logic has_regs(input logic [3:0] ic);
      case (ic)
         I_RRMOVL, I_IRMOVL, I_RMMOVL, I_MRMOVL,
         I_OPL, I_PUSHL, I_POPL: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic has_valc(input logic [3:0] ic);
      case (ic)
         I_IRMOVL, I_RMMOVL, I_MRMOVL, I_JXX, I_CALL: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

   // Illegal opcodes occupy a single byte so the fault is reported without further reads.
   function automatic logic [3:0] instr_len(input logic [3:0] ic, input int unsigned valc_bytes);
      int unsigned n;
      n = 1;
      if (valid_icode(ic)) begin
         if (has_regs(ic)) n += 1;
         if (has_valc(ic)) n += valc_bytes;
      end
      return 4'(n);
   endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Combinational icode classifier: legality, presence of register/constant bytes and total length.
module fetch_len_decode
   import y86_pkg::*;
#(
   parameter int VALC_BYTES = 4
) (
   input  logic [3:0] icode_i,
   output logic       valid_o,
   output logic       has_regs_o,
   output logic       has_valc_o,
   output logic [3:0] len_o
);

   assign valid_o    = valid_icode(icode_i);
   assign has_regs_o = has_regs(icode_i);
   assign has_valc_o = has_valc(icode_i);
   assign len_o      = instr_len(icode_i, VALC_BYTES);

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial Y86-32 instruction fetch: one byte per accepted mem_ready, done one cycle after the last byte.
// Memory stalls simply hold the current request; fetch_start is only honoured in IDLE.
module fetch_unit
   import y86_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int VALC_BYTES = 4
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    fetch_start,
   input  logic [ADDR_W-1:0]       pc,
   output logic                    busy,
   output logic                    fetch_done,
   output logic                    mem_rd,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic [7:0]              mem_rdata,
   input  logic                    mem_ready,
   input  logic                    mem_error,
   output logic [3:0]              icode,
   output logic [3:0]              ifun,
   output logic [3:0]              rA,
   output logic [3:0]              rB,
   output logic [8*VALC_BYTES-1:0] valC,
   output logic [ADDR_W-1:0]       valP,
   output logic                    instr_valid,
   output logic                    imem_error
);

   localparam int CW = (VALC_BYTES > 1) ? $clog2(VALC_BYTES) : 1;

   fetch_state_e            state_q, state_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   logic [3:0]              off_q, off_d;
   logic [CW-1:0]           cidx_q, cidx_d;
   logic [3:0]              icode_q, icode_d, ifun_q, ifun_d;
   logic [3:0]              ra_q, ra_d, rb_q, rb_d;
   logic [8*VALC_BYTES-1:0] valc_q, valc_d;
   logic [ADDR_W-1:0]       valp_q, valp_d;
   logic                    valid_q, valid_d, err_q, err_d;

   logic [3:0] dec_icode, dec_len;
   logic       dec_valid, dec_regs, dec_valc;
   logic       accept, last;

   // The opcode byte is classified straight off the bus so the OPC exit decision needs no extra cycle.
   assign dec_icode = (state_q == S_OPC) ? mem_rdata[7:4] : icode_q;

   fetch_len_decode #(.VALC_BYTES(VALC_BYTES)) u_len_decode (
      .icode_i    (dec_icode),
      .valid_o    (dec_valid),
      .has_regs_o (dec_regs),
      .has_valc_o (dec_valc),
      .len_o      (dec_len)
   );

   assign busy       = (state_q == S_OPC) || (state_q == S_REGS) || (state_q == S_CONST);
   assign mem_rd     = busy;
   assign mem_addr   = mem_rd ? (base_q + ADDR_W'(off_q)) : '0;
   assign fetch_done = (state_q == S_DONE);
   assign accept     = mem_rd && mem_ready;
   assign last       = ((off_q + 4'd1) == dec_len);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      off_d   = off_q;
      cidx_d  = cidx_q;
      icode_d = icode_q;
      ifun_d  = ifun_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      valc_d  = valc_q;
      valp_d  = valp_q;
      valid_d = valid_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (fetch_start) begin
               state_d = S_OPC;
               base_d  = pc;
               off_d   = '0;
               cidx_d  = '0;
               icode_d = '0;
               ifun_d  = '0;
               ra_d    = REG_NONE;
               rb_d    = REG_NONE;
               valc_d  = '0;
               valp_d  = '0;
               valid_d = 1'b0;
               err_d   = 1'b0;
            end
         end
         S_OPC, S_REGS, S_CONST: begin
            if (accept) begin
               off_d = off_q + 4'd1;
               if (mem_error) begin
                  // A faulting byte is counted in valP but its contents are discarded.
                  err_d   = 1'b1;
                  valid_d = 1'b0;
                  valp_d  = base_q + ADDR_W'(off_d);
                  state_d = S_DONE;
               end else begin
                  case (state_q)
                     S_OPC: begin
                        icode_d = mem_rdata[7:4];
                        ifun_d  = mem_rdata[3:0];
                        valid_d = dec_valid;
                     end
                     S_REGS: begin
                        ra_d = mem_rdata[7:4];
                        rb_d = mem_rdata[3:0];
                     end
                     default: begin
                        valc_d[8*int'(cidx_q) +: 8] = mem_rdata;
                        cidx_d                      = cidx_q + CW'(1);
                     end
                  endcase
                  if (last) begin
                     valp_d  = base_q + ADDR_W'(off_d);
                     state_d = S_DONE;
                  end else if (state_q == S_OPC && dec_regs) begin
                     state_d = S_REGS;
                  end else if (dec_valc) begin
                     state_d = S_CONST;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         off_q   <= '0;
         cidx_q  <= '0;
         icode_q <= '0;
         ifun_q  <= '0;
         ra_q    <= REG_NONE;
         rb_q    <= REG_NONE;
         valc_q  <= '0;
         valp_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         off_q   <= off_d;
         cidx_q  <= cidx_d;
         icode_q <= icode_d;
         ifun_q  <= ifun_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         valc_q  <= valc_d;
         valp_q  <= valp_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign icode       = icode_q;
   assign ifun        = ifun_q;
   assign rA          = ra_q;
   assign rB          = rb_q;
   assign valC        = valc_q;
   assign valP        = valp_q;
   assign instr_valid = valid_q;
   assign imem_error  = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a table-driven instruction-length model with a byte memory.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        fetch_start = 1'b0;
   logic [31:0] pc = '0;
   logic        busy, fetch_done, mem_rd;
   logic [31:0] mem_addr;
   logic [7:0]  mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        mem_error = 1'b0;
   logic [3:0]  icode, ifun, rA, rB;
   logic [31:0] valC, valP;
   logic        instr_valid, imem_error;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] imem [logic [31:0]];
   int len_tab [16] = '{1, 1, 2, 6, 6, 6, 2, 5, 5, 1, 2, 2, 1, 1, 1, 1};
   localparam logic [116:0] RST_VEC = {3'b000, 32'h0, 8'h00, 8'hFF, 32'h0, 32'h0, 2'b00};

   always #5 CLK = ~CLK;

   fetch_unit #(.ADDR_W(32), .VALC_BYTES(4)) dut (
      .CLK(CLK), .RESET(RESET), .fetch_start(fetch_start), .pc(pc),
      .busy(busy), .fetch_done(fetch_done), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error),
      .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
      .instr_valid(instr_valid), .imem_error(imem_error)
   );

   function automatic logic [7:0] rd(input logic [31:0] a);
      return imem.exists(a) ? imem[a] : 8'h00;
   endfunction

   function automatic logic [116:0] out_vec();
      return {busy, fetch_done, mem_rd, mem_addr, icode, ifun, rA, rB, valC, valP, instr_valid, imem_error};
   endfunction

   task automatic load(input logic [31:0] a, input logic [47:0] bytes_be);
      for (int k = 0; k < 6; k++) imem[a + 32'(k)] = bytes_be[47-8*k -: 8];
   endtask

   // waits<0: random 0..2 wait cycles per byte; err_at<0: no fault; abort_at>0: reset at that cycle.
   task automatic do_fetch(input string nm, input logic [31:0] pc_v, input int waits,
                           input int err_at, input int abort_at);
      logic [7:0]  op;
      logic [3:0]  e_ic, e_if, e_ra, e_rb;
      logic [31:0] e_valc, e_valp;
      logic        e_valid, e_err;
      int n, n_acc, cap, idx, cyc, nacc, wcnt, wait_tot, cur_w;
      bit done;

      op      = rd(pc_v);
      n       = len_tab[op[7:4]];
      e_err   = (err_at >= 0) && (err_at < n);
      n_acc   = e_err ? err_at + 1 : n;
      cap     = e_err ? err_at : n;
      e_ic    = (cap > 0) ? op[7:4] : 4'h0;
      e_if    = (cap > 0) ? op[3:0] : 4'h0;
      e_valid = !e_err && (op[7:4] <= 4'hB);
      e_ra    = 4'hF;
      e_rb    = 4'hF;
      if ((n == 2 || n == 6) && cap > 1) {e_ra, e_rb} = rd(pc_v + 32'd1);
      e_valc = '0;
      if (n >= 5)
         for (int k = 0; k < 4; k++) begin
            idx = ((n == 6) ? 2 : 1) + k;
            if (idx < cap) e_valc[8*k +: 8] = rd(pc_v + 32'(idx));
         end
      e_valp = pc_v + 32'(n_acc);

      @(negedge CLK);
      fetch_start = 1'b1;
      pc          = pc_v;
      mem_ready   = 1'b0;
      mem_error   = 1'b0;
      @(posedge CLK);
      cyc = 0; nacc = 0; wcnt = 0; wait_tot = 0; done = 0;
      cur_w = (waits >= 0) ? waits : $urandom_range(0, 2);
      while (!done && cyc < 200) begin
         @(negedge CLK);
         cyc++;
         fetch_start = 1'($urandom_range(0, 1));
         pc          = $urandom;
         if (cyc == abort_at) begin
            RESET = 1'b1;
            #1;
            n_cmp++;
            if (out_vec() !== RST_VEC) begin
               n_bad++;
               $display("FAIL %s.reset_outputs got %h want %h", nm, out_vec(), RST_VEC);
            end
            fetch_start = 1'b0;
            mem_ready   = 1'b0;
            mem_error   = 1'b0;
            @(negedge CLK);
            RESET = 1'b0;
            for (int c = 0; c < 2; c++) begin
               @(negedge CLK);
               n_cmp++;
               if ({fetch_done, busy} !== 2'b00) begin
                  n_bad++;
                  $display("FAIL %s.post_reset_idle got done/busy %b want 00", nm, {fetch_done, busy});
               end
            end
            return;
         end
         if (fetch_done === 1'b1) begin
            done = 1;
         end else begin
            n_cmp++;
            if ({busy, mem_rd} !== 2'b11) begin
               n_bad++;
               $display("FAIL %s.busy_rd cyc %0d got %b want 11", nm, cyc, {busy, mem_rd});
            end
            n_cmp++;
            if (nacc >= n_acc) begin
               n_bad++;
               $display("FAIL %s.over_read cyc %0d got read %0d want at most %0d", nm, cyc, nacc + 1, n_acc);
            end
            n_cmp++;
            if (mem_addr !== pc_v + 32'(nacc)) begin
               n_bad++;
               $display("FAIL %s.mem_addr cyc %0d got %h want %h", nm, cyc, mem_addr, pc_v + 32'(nacc));
            end
            if (wcnt < cur_w) begin
               mem_ready = 1'b0;
               mem_rdata = 8'($urandom);
               mem_error = 1'($urandom_range(0, 1));
               wcnt++;
               wait_tot++;
            end else begin
               mem_ready = 1'b1;
               mem_rdata = rd(pc_v + 32'(nacc));
               mem_error = (nacc == err_at);
               nacc++;
               wcnt  = 0;
               cur_w = (waits >= 0) ? waits : $urandom_range(0, 2);
            end
         end
      end
      mem_ready = 1'b0;
      mem_error = 1'b0;
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s.timeout got no fetch_done want done by cycle %0d", nm, 1 + n_acc + wait_tot);
         return;
      end
      n_cmp++;
      if (cyc != 1 + n_acc + wait_tot) begin
         n_bad++;
         $display("FAIL %s.done_cycle got %0d want %0d", nm, cyc, 1 + n_acc + wait_tot);
      end
      n_cmp++;
      if ({busy, mem_rd} !== 2'b00) begin
         n_bad++;
         $display("FAIL %s.done_busy_rd got %b want 00", nm, {busy, mem_rd});
      end
      n_cmp++;
      if ({icode, ifun, rA, rB} !== {e_ic, e_if, e_ra, e_rb}) begin
         n_bad++;
         $display("FAIL %s.fields got %h want %h", nm, {icode, ifun, rA, rB}, {e_ic, e_if, e_ra, e_rb});
      end
      n_cmp++;
      if (valC !== e_valc) begin
         n_bad++;
         $display("FAIL %s.valC got %h want %h", nm, valC, e_valc);
      end
      n_cmp++;
      if (valP !== e_valp) begin
         n_bad++;
         $display("FAIL %s.valP got %h want %h", nm, valP, e_valp);
      end
      n_cmp++;
      if ({instr_valid, imem_error} !== {e_valid, e_err}) begin
         n_bad++;
         $display("FAIL %s.valid_err got %b want %b", nm, {instr_valid, imem_error}, {e_valid, e_err});
      end
      @(negedge CLK);
      fetch_start = 1'b0;
      n_cmp++;
      if ({fetch_done, busy, mem_rd, valP, valC} !== {3'b000, e_valp, e_valc}) begin
         n_bad++;
         $display("FAIL %s.after_done got %h want %h", nm, {fetch_done, busy, mem_rd, valP, valC},
                  {3'b000, e_valp, e_valc});
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (out_vec() !== RST_VEC) begin
         n_bad++;
         $display("FAIL reset.outputs got %h want %h", out_vec(), RST_VEC);
      end
      RESET = 1'b0;
   endtask

   task automatic test_nop();
      load(32'h10, 48'h10_00_00_00_00_00);
      do_fetch("nop", 32'h10, 0, -1, 0);
   endtask

   task automatic test_irmovl();
      load(32'h100, 48'h30_F3_78_56_34_12);
      do_fetch("irmovl", 32'h100, 0, -1, 0);
   endtask

   task automatic test_call_waits();
      load(32'h20, 48'h80_00_02_00_00_77);
      do_fetch("call_wait", 32'h20, 2, -1, 0);
   endtask

   task automatic test_wrap();
      load(32'hFFFF_FFFE, 48'h20_12_55_55_55_55);
      do_fetch("wrap", 32'hFFFF_FFFE, 0, -1, 0);
   endtask

   task automatic test_illegal_and_fault();
      load(32'h60, 48'hC0_11_22_33_44_55);
      do_fetch("illegal", 32'h60, 0, -1, 0);
      load(32'h40, 48'h50_12_34_56_78_9A);
      do_fetch("fault", 32'h40, 0, 2, 0);
      do_fetch("fault_opc", 32'h40, 1, 0, 0);
   endtask

   task automatic test_reset_mid();
      load(32'h100, 48'h30_F3_78_56_34_12);
      do_fetch("abort", 32'h100, 0, -1, 4);
      do_fetch("after_abort", 32'h100, 0, -1, 0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      int e;
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 6)) : $urandom;
         load(a, {$urandom, 16'($urandom)});
         e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1;
         do_fetch("random", a, -1, e, 0);
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_irmovl();
      test_call_waits();
      test_wrap();
      test_illegal_and_fault();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
